// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with
// freeze, kill, bubble insertion and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              bubble_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q,  data_d;
    logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [CNT_W-1:0]             cnt_q,   cnt_d;

    // Next-state for every slot; priority is kill, freeze, bubble, advance.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            valid_d = '0;
            data_d  = '0;
            ctrl_d  = '0;
        end else if (stall_i) begin
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                data_d[k]  = data_q[k-1];
                ctrl_d[k]  = ctrl_q[k-1];
            end
            if (bubble_i) begin
                valid_d[0] = 1'b0;
                data_d[0]  = '0;
                ctrl_d[0]  = '0;
            end else begin
                valid_d[0] = valid_i;
                data_d[0]  = data_i;
                ctrl_d[0]  = valid_i ? ctrl_i : '0;
            end
        end
    end

    // Slot registers and counter; reset overrides everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o     = valid_q[DEPTH-1];
    assign data_o      = data_q[DEPTH-1];
    assign ctrl_o      = ctrl_q[DEPTH-1];
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vectors into an expected-value queue,
// checked by an independent monitor one delta after each rising edge.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_i, stall_i, flush_i, bubble_i, valid_i;
    logic [31:0] data_i;
    logic [3:0]  ctrl_i;
    logic        valid_o;
    logic [31:0] data_o;
    logic [3:0]  ctrl_o;
    logic [3:0]  stall_cnt_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [3:0]  c;
        logic [3:0]  n;
        string       nm;
    } exp_t;

    exp_t sb[$];

    pipe_stage_reg #(
        .DATA_W(32), .CTRL_W(4), .DEPTH(2), .CNT_W(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i),
        .flush_i(flush_i), .bubble_i(bubble_i),
        .valid_i(valid_i), .data_i(data_i), .ctrl_i(ctrl_i),
        .valid_o(valid_o), .data_o(data_o), .ctrl_o(ctrl_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic r, input logic s, input logic f,
                        input logic b, input logic v,
                        input logic [31:0] d, input logic [3:0] c,
                        input logic ev, input logic [31:0] ed,
                        input logic [3:0] ec, input logic [3:0] en,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rst_i = r; stall_i = s; flush_i = f; bubble_i = b;
        valid_i = v; data_i = d; ctrl_i = c;
        e.v = ev; e.d = ed; e.c = ec; e.n = en; e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor: pop and compare on every edge where an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({valid_o, data_o, ctrl_o, stall_cnt_o} !==
                    {e.v, e.d, e.c, e.n}) begin
                    errors++;
                    $display("FAIL %s: got v=%b d=%h c=%h n=%0d want v=%b d=%h c=%h n=%0d",
                             e.nm, valid_o, data_o, ctrl_o, stall_cnt_o,
                             e.v, e.d, e.c, e.n);
                end
                checks++;
                if (!valid_o && ctrl_o !== 4'h0) begin
                    errors++;
                    $display("FAIL %s_mask: got ctrl=%h with valid=0 want 0",
                             e.nm, ctrl_o);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; bubble_i = 1'b0;
        valid_i = 1'b0; data_i = '0; ctrl_i = '0;

        // Reset then pass-through
        step(1,0,0,0,0,32'h0, 4'h0, 0,32'h0, 4'h0,0,"rst0");
        step(1,0,0,0,1,32'h99,4'h3, 0,32'h0, 4'h0,0,"rst1");
        step(0,0,0,0,1,32'h10,4'h3, 0,32'h0, 4'h0,0,"pt0");
        step(0,0,0,0,1,32'h14,4'h3, 1,32'h10,4'h3,0,"pt1");
        step(0,0,0,0,1,32'h18,4'h3, 1,32'h14,4'h3,0,"pt2");
        step(0,0,0,0,0,32'h0, 4'h0, 1,32'h18,4'h3,0,"pt3");
        step(0,0,0,0,0,32'h0, 4'h0, 0,32'h0, 4'h0,0,"pt4");

        // Stall hold
        step(0,0,0,0,1,32'hA0,4'h1, 0,32'h0, 4'h0,0,"st0");
        step(0,0,0,0,1,32'hA4,4'h1, 1,32'hA0,4'h1,0,"st1");
        step(0,1,0,0,1,32'hA8,4'h1, 1,32'hA0,4'h1,1,"st2");
        step(0,1,0,0,1,32'hA8,4'h1, 1,32'hA0,4'h1,2,"st3");
        step(0,1,0,0,1,32'hA8,4'h1, 1,32'hA0,4'h1,3,"st4");
        step(0,0,0,0,1,32'hA8,4'h1, 1,32'hA4,4'h1,3,"st5");
        step(0,0,0,0,0,32'h0, 4'h0, 1,32'hA8,4'h1,3,"st6");
        step(0,0,0,0,0,32'h0, 4'h0, 0,32'h0, 4'h0,3,"st7");

        // Flush over stall
        step(0,0,0,0,1,32'hC0,4'hF, 0,32'h0, 4'h0,3,"fl0");
        step(0,0,0,0,1,32'hC4,4'hF, 1,32'hC0,4'hF,3,"fl1");
        step(0,1,1,0,1,32'hC8,4'hF, 0,32'h0, 4'h0,3,"fl2");
        step(0,0,0,0,1,32'hCC,4'hF, 0,32'h0, 4'h0,3,"fl3");
        step(0,0,0,0,0,32'h0, 4'h0, 1,32'hCC,4'hF,3,"fl4");
        step(0,0,0,0,0,32'h0, 4'h0, 0,32'h0, 4'h0,3,"fl5");

        // Bubble insertion
        step(0,0,0,0,1,32'hB0,4'h5, 0,32'h0, 4'h0,3,"bb0");
        step(0,0,0,1,1,32'hB4,4'h5, 1,32'hB0,4'h5,3,"bb1");
        step(0,0,0,0,0,32'h0, 4'h0, 0,32'h0, 4'h0,3,"bb2");
        step(0,0,0,0,0,32'h0, 4'h0, 0,32'h0, 4'h0,3,"bb3");

        // Invalid input masking
        step(0,0,0,0,0,32'h1234,4'hF, 0,32'h0,   4'h0,3,"iv0");
        step(0,0,0,0,0,32'h0,   4'h0, 0,32'h1234,4'h0,3,"iv1");
        step(0,0,0,0,0,32'h0,   4'h0, 0,32'h0,   4'h0,3,"iv2");

        // Stall and bubble together: stall wins
        step(0,0,0,0,1,32'hD0,4'h2, 0,32'h0, 4'h0,3,"sb0");
        step(0,1,0,1,1,32'hD4,4'h2, 0,32'h0, 4'h0,4,"sb1");
        step(0,0,0,0,1,32'hD4,4'h2, 1,32'hD0,4'h2,4,"sb2");
        step(0,0,0,0,0,32'h0, 4'h0, 1,32'hD4,4'h2,4,"sb3");
        step(0,0,0,0,0,32'h0, 4'h0, 0,32'h0, 4'h0,4,"sb4");

        // Mid-stream reset
        step(0,0,0,0,1,32'hE0,4'h6, 0,32'h0, 4'h0,4,"mr0");
        step(1,1,0,0,1,32'hE4,4'h6, 0,32'h0, 4'h0,0,"mr1");
        step(0,0,0,0,0,32'h0, 4'h0, 0,32'h0, 4'h0,0,"mr2");

        // Counter saturation at 15
        for (int k = 1; k <= 20; k++) begin
            step(0,1,0,0,0,32'h0,4'h0, 0,32'h0,4'h0,
                 (k > 15) ? 4'd15 : 4'(k), $sformatf("sat%0d", k));
        end
        step(1,0,0,0,0,32'h0,4'h0, 0,32'h0,4'h0,0,"satrst");
        step(0,0,0,0,0,32'h0,4'h0, 0,32'h0,4'h0,0,"satidle");

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
